rf_read_control: RTL and testbench
==================================

# rf_read_control

Operand-read (decode/RF stage) controller for the 4-stage pipelined 8-bit processor; the read-side counterpart of write-back control. Each cycle it decodes the instruction in IR2, checks its source registers against a scoreboard of in-flight register writes, and either issues the instruction to EX or stalls the front end and injects a bubble. The scoreboard is incremented at issue and decremented when write-back performs the corresponding register-file write.

## Interface
Parameters:
- NREG, 4, number of architectural registers; register address width is 2.
- CMAX, 3, saturation value of each per-register in-flight counter; counter width is 2.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- IR2  in  8  instruction in decode stage: [7:6] Rx, [5:4] Ry, [3:0] opcode.
- IR2Valid  in  1  IR2 holds a real instruction; 0 = empty slot.
- Squash  in  1  branch taken in EX: the decode instruction is discarded this cycle.
- WBRFWrite  in  1  write-back writes the register file this cycle.
- WBReg  in  2  destination register of that write.
- Issue  out  1  IR2 moves to EX this cycle.
- Stall  out  1  hold PC, IR1, IR2.
- Bubble  out  1  load NOP (1010) into IR3 instead of IR2.
- Busy  out  4  bit r = counter[r] != 0.
- Halted  out  1  STOP has issued; sticky until reset.
- ScbErr  out  1  sticky: a decrement hit a zero counter.

## Operation
- Decode (combinational), source set / destination:
  - load 0000: reads Ry, writes Rx.
  - store 0010: reads Rx, Ry; no write.
  - add 0100, sub 0110, nand 1000: read Rx, Ry; write Rx.
  - ori xxx111: reads and writes R1.
  - shift xxx011: reads and writes Rx.
  - bz 0101, bnz 1001, bpz 1101, nop 1010: no reads, no write.
  - stop 0001: no reads, no write; sets Halted on issue.
  - Any other opcode: treated as nop.
- Hazard = IR2Valid and (any source counter != 0, or destination counter == CMAX).
- Issue = IR2Valid & ~Squash & ~Hazard & ~Halted.
- Stall = IR2Valid & ~Squash & (Hazard | Halted).
- Bubble = ~Issue.
- Counter update per register r, at the clock edge:
  - inc = Issue & writes & dest==r; dec = WBRFWrite & WBReg==r.
  - inc & dec: unchanged.
  - inc only: +1, saturating at CMAX. Saturation is unreachable when Hazard is honoured.
  - dec only: −1; if the counter is 0 it stays 0 and ScbErr sets.
- Squash takes priority over issue; it never alters counters. Writes already past decode still complete and decrement normally.
- Halted: once set, Issue stays 0 for every later instruction.

## Timing
- Reset values: all counters 0; Halted 0; ScbErr 0. Issue, Stall and Bubble follow the combinational equations with zero counters, so with IR2Valid=0, Issue=0, Stall=0, Bubble=1.
- Hazard, Issue, Stall and Bubble are combinational from IR2, IR2Valid, Squash and the registered counters. They do not depend on WBRFWrite or WBReg in the same cycle; there is no bypass.
- A write-back in cycle N clears Busy in cycle N+1. The dependent instruction issues in N+1, when the register file (written on the same edge) already holds the new value.
- Back-to-back dependency: producer issues in cycle 0 and reaches WB in cycle 2, so the consumer stalls in cycles 1–2 and issues in cycle 3.
- Reset mid-stall: all state clears immediately. In-flight write-backs after reset decrement zero counters and set ScbErr. The bench must reset the whole pipeline together.

## Structure
- Shared package: opcode constants (OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_NAND, OP_ORI, OP_SHIFT, OP_BZ, OP_BNZ, OP_BPZ, OP_STOP, OP_NOP), field positions for Rx, Ry and opcode, NOP encoding. The write-back controller uses the same constants.
- One sub-module, ir_src_decode: maps IR2 to {rdA_en, rdA, rdB_en, rdB, wr_en, wr_reg, is_stop}. It is combinational and reusable by the forwarding logic.
- The top level holds the counter array, Halted, ScbErr and the issue/stall equations.

## Test plan
- Reset, then IR2=add R1,R2 (01100100) valid, idle scoreboard → Issue=1, Stall=0; next cycle Busy=0010.
- add R1,R2 followed by sub R2,R1 (10010110) → the sub stalls 2 cycles with Bubble=1. WBRFWrite, WBReg=01 in cycle 2; the sub issues in cycle 3 and Busy=0000 afterwards.
- Issue ori (R1 write) in the same cycle as WBRFWrite, WBReg=01 with counter[1]=1 → counter[1] stays 1.
- Stalled load with Squash=1 → Issue=0, Stall=0, Bubble=1, counters unchanged.
- WBRFWrite with WBReg=11 while counter[3]=0 → ScbErr=1 and stays set; counter[3]=0.
- Issue stop (00000001) then add → Halted=1; the add holds with Stall=1 indefinitely until reset, which clears Halted.

Source files
------------

// File: rtl/rf_read_control_pkg.sv
// rtl/rf_read_control_pkg.sv - shared opcode, field and decode definitions for the 8-bit pipeline
package rf_read_control_pkg;

  localparam int RX_MSB = 7;
  localparam int RX_LSB = 6;
  localparam int RY_MSB = 5;
  localparam int RY_LSB = 4;
  localparam int OP_MSB = 3;
  localparam int OP_LSB = 0;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_SHIFT = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_NOP   = 4'b1010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;

  // ori and shift are recognised by their low three opcode bits only
  localparam logic [2:0] ORI_LOW   = 3'b111;
  localparam logic [2:0] SHIFT_LOW = 3'b011;

  localparam logic [1:0] ORI_REG   = 2'd1;
  localparam logic [7:0] NOP_INSTR = {4'b0000, OP_NOP};

endpackage

// File: rtl/rf_read_control_ir_src_decode.sv
// rtl/rf_read_control_ir_src_decode.sv - combinational source/destination decode of IR2
module ir_src_decode
  import rf_read_control_pkg::*;
(
  input  logic [7:0] ir,
  output logic       rdA_en,
  output logic [1:0] rdA,
  output logic       rdB_en,
  output logic [1:0] rdB,
  output logic       wr_en,
  output logic [1:0] wr_reg,
  output logic       is_stop
);

  logic [1:0] rx;
  logic [1:0] ry;
  logic [3:0] op;

  assign rx = ir[RX_MSB:RX_LSB];
  assign ry = ir[RY_MSB:RY_LSB];
  assign op = ir[OP_MSB:OP_LSB];

  always_comb begin
    rdA_en  = 1'b0;
    rdA     = 2'd0;
    rdB_en  = 1'b0;
    rdB     = 2'd0;
    wr_en   = 1'b0;
    wr_reg  = 2'd0;
    is_stop = 1'b0;
    if (op[2:0] == ORI_LOW) begin
      rdA_en = 1'b1;
      rdA    = ORI_REG;
      wr_en  = 1'b1;
      wr_reg = ORI_REG;
    end else if (op[2:0] == SHIFT_LOW) begin
      rdA_en = 1'b1;
      rdA    = rx;
      wr_en  = 1'b1;
      wr_reg = rx;
    end else begin
      case (op)
        OP_LOAD: begin
          rdB_en = 1'b1;
          rdB    = ry;
          wr_en  = 1'b1;
          wr_reg = rx;
        end
        OP_STORE: begin
          rdA_en = 1'b1;
          rdA    = rx;
          rdB_en = 1'b1;
          rdB    = ry;
        end
        OP_ADD, OP_SUB, OP_NAND: begin
          rdA_en = 1'b1;
          rdA    = rx;
          rdB_en = 1'b1;
          rdB    = ry;
          wr_en  = 1'b1;
          wr_reg = rx;
        end
        OP_STOP: is_stop = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rf_read_control.sv
// rtl/rf_read_control.sv - decode-stage scoreboard, issue/stall/bubble control
module rf_read_control
  import rf_read_control_pkg::*;
#(
  parameter int NREG = 4,
  parameter int CMAX = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              IR2,
  input  logic                    IR2Valid,
  input  logic                    Squash,
  input  logic                    WBRFWrite,
  input  logic [$clog2(NREG)-1:0] WBReg,
  output logic                    Issue,
  output logic                    Stall,
  output logic                    Bubble,
  output logic [NREG-1:0]         Busy,
  output logic                    Halted,
  output logic                    ScbErr
);

  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);

  logic          rdA_en, rdB_en, wr_en, is_stop;
  logic [1:0]    rdA, rdB, wr_reg;
  logic [CW-1:0] cnt [NREG];
  logic [NREG-1:0] inc_vec, dec_vec;
  logic          hazard;

  ir_src_decode u_decode (
    .ir      (IR2),
    .rdA_en  (rdA_en),
    .rdA     (rdA),
    .rdB_en  (rdB_en),
    .rdB     (rdB),
    .wr_en   (wr_en),
    .wr_reg  (wr_reg),
    .is_stop (is_stop)
  );

  // No bypass: hazard looks only at registered counters, never at this cycle's write-back
  always_comb begin
    hazard = IR2Valid && ((rdA_en && cnt[AW'(rdA)] != '0) ||
                          (rdB_en && cnt[AW'(rdB)] != '0) ||
                          (wr_en && cnt[AW'(wr_reg)] == CNT_MAX));
    Issue  = IR2Valid && !Squash && !hazard && !Halted;
    Stall  = IR2Valid && !Squash && (hazard || Halted);
    Bubble = !Issue;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      Busy[r]    = (cnt[r] != '0);
      inc_vec[r] = Issue && wr_en && (AW'(wr_reg) == AW'(r));
      dec_vec[r] = WBRFWrite && (WBReg == AW'(r));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      Halted <= 1'b0;
      ScbErr <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        case ({inc_vec[r], dec_vec[r]})
          2'b10:   if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CW'(1);
          2'b01:   if (cnt[r] != '0) cnt[r] <= cnt[r] - CW'(1);
          default: ;
        endcase
      end
      if (|(dec_vec & ~inc_vec & ~Busy)) ScbErr <= 1'b1;
      if (Issue && is_stop) Halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_read_control.sv
// tb/tb_rf_read_control.sv - directed and randomized self-checking bench with a scoreboard model
module tb_rf_read_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] IR2 = 8'h00;
  logic       IR2Valid = 1'b0;
  logic       Squash = 1'b0;
  logic       WBRFWrite = 1'b0;
  logic [1:0] WBReg = 2'd0;
  logic       Issue, Stall, Bubble, Halted, ScbErr;
  logic [3:0] Busy;

  int checks = 0;
  int failures = 0;

  int  mcnt [4];
  bit  mhalted, mscberr;
  logic obs_issue, obs_stall, obs_bubble;

  rf_read_control #(.NREG(4), .CMAX(3)) dut (
    .clock(clock), .reset(reset), .IR2(IR2), .IR2Valid(IR2Valid), .Squash(Squash),
    .WBRFWrite(WBRFWrite), .WBReg(WBReg), .Issue(Issue), .Stall(Stall), .Bubble(Bubble),
    .Busy(Busy), .Halted(Halted), .ScbErr(ScbErr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: list of sources (-1 = none) and destination (-1 = none)
  task automatic ref_decode(input logic [7:0] ir, output int s0, output int s1,
                            output int dst, output bit stop);
    int rx, ry;
    logic [3:0] op;
    rx = int'(ir[7:6]);
    ry = int'(ir[5:4]);
    op = ir[3:0];
    s0 = -1; s1 = -1; dst = -1; stop = 0;
    casez (op)
      4'b?111: begin s0 = 1; dst = 1; end
      4'b?011: begin s0 = rx; dst = rx; end
      4'b0000: begin s0 = ry; dst = rx; end
      4'b0010: begin s0 = rx; s1 = ry; end
      4'b0100, 4'b0110, 4'b1000: begin s0 = rx; s1 = ry; dst = rx; end
      4'b0001: stop = 1;
      default: ;
    endcase
  endtask

  function automatic logic [3:0] model_busy();
    logic [3:0] b;
    for (int r = 0; r < 4; r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_busy"}, {4'h0, Busy}, {4'h0, model_busy()});
    chk({tag, "_halted"}, {7'h0, Halted}, {7'h0, mhalted});
    chk({tag, "_scberr"}, {7'h0, ScbErr}, {7'h0, mscberr});
  endtask

  task automatic do_reset();
    @(negedge clock);
    IR2Valid = 1'b0; Squash = 1'b0; WBRFWrite = 1'b0;
    reset = 1'b1;
    for (int r = 0; r < 4; r++) mcnt[r] = 0;
    mhalted = 0; mscberr = 0;
    #1;
    check_state("rst");
    chk("rst_issue", {7'h0, Issue}, 8'h00);
    chk("rst_stall", {7'h0, Stall}, 8'h00);
    chk("rst_bubble", {7'h0, Bubble}, 8'h01);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Drive one cycle from a negedge, check combinational outputs, clock, update model
  task automatic step(input string tag, input logic [7:0] ir, input logic v, input logic sq,
                      input logic wbw, input logic [1:0] wbr);
    int s0, s1, dst;
    bit stop, haz, iss, stl;
    IR2 = ir; IR2Valid = v; Squash = sq; WBRFWrite = wbw; WBReg = wbr;
    #1;
    ref_decode(ir, s0, s1, dst, stop);
    haz = v && ((s0 >= 0 && mcnt[s0] != 0) || (s1 >= 0 && mcnt[s1] != 0) ||
                (dst >= 0 && mcnt[dst] == 3));
    iss = v && !sq && !haz && !mhalted;
    stl = v && !sq && (haz || mhalted);
    obs_issue = Issue; obs_stall = Stall; obs_bubble = Bubble;
    chk({tag, "_issue"}, {7'h0, Issue}, {7'h0, iss});
    chk({tag, "_stall"}, {7'h0, Stall}, {7'h0, stl});
    chk({tag, "_bubble"}, {7'h0, Bubble}, {7'h0, !iss});
    @(posedge clock);
    for (int r = 0; r < 4; r++) begin
      bit inc, dec;
      inc = iss && (dst == r);
      dec = wbw && (int'(wbr) == r);
      if (inc && !dec && mcnt[r] < 3) mcnt[r]++;
      else if (dec && !inc) begin
        if (mcnt[r] == 0) mscberr = 1;
        else mcnt[r]--;
      end
    end
    if (iss && stop) mhalted = 1;
    @(negedge clock);
    check_state(tag);
  endtask

  initial begin
    do_reset();

    // add R1,R2 on idle scoreboard, then dependent sub R2,R1
    step("add", 8'h64, 1, 0, 0, 2'd0);
    chk("add_issue_c", {7'h0, obs_issue}, 8'h01);
    chk("add_busy_c", {4'h0, Busy}, 8'h02);
    step("sub1", 8'h96, 1, 0, 0, 2'd0);
    chk("sub1_stall_c", {6'h0, obs_stall, obs_bubble}, 8'h03);
    step("sub2", 8'h96, 1, 0, 1, 2'd1);
    chk("sub2_stall_c", {6'h0, obs_stall, obs_bubble}, 8'h03);
    step("sub3", 8'h96, 1, 0, 0, 2'd0);
    chk("sub3_issue_c", {7'h0, obs_issue}, 8'h01);
    step("sub_wb", 8'h00, 0, 0, 1, 2'd2);
    chk("sub_busy_c", {4'h0, Busy}, 8'h00);

    // write to R1 issuing in the same cycle as R1 write-back: counter holds at 1
    step("ldr1a", 8'h40, 1, 0, 0, 2'd0);
    step("ldr1b", 8'h40, 1, 0, 1, 2'd1);
    chk("inc_dec_c", {4'h0, Busy}, 8'h02);
    step("ldr1_wb", 8'h00, 0, 0, 1, 2'd1);

    // squashed stalled load leaves counters alone
    step("ldr0", 8'h00, 1, 0, 0, 2'd0);
    step("squash", 8'h40, 1, 1, 0, 2'd0);
    chk("squash_c", {5'h0, obs_issue, obs_stall, obs_bubble}, 8'h01);
    chk("squash_busy_c", {4'h0, Busy}, 8'h01);
    step("ldr0_wb", 8'h00, 0, 0, 1, 2'd0);

    // decrement of an idle counter
    step("err", 8'h00, 0, 0, 1, 2'd3);
    chk("err_c", {3'h0, ScbErr, Busy}, 8'h10);
    step("err_hold", 8'h00, 0, 0, 0, 2'd0);
    chk("err_hold_c", {7'h0, ScbErr}, 8'h01);

    // stop, then an add that can never issue
    step("stop", 8'h01, 1, 0, 0, 2'd0);
    chk("halted_c", {7'h0, Halted}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      step("halt_add", 8'h64, 1, 0, 0, 2'd0);
      chk("halt_stall_c", {6'h0, obs_issue, obs_stall}, 8'h01);
    end
    do_reset();
    chk("halt_clr_c", {7'h0, Halted}, 8'h00);

    // randomized traffic with periodic whole-pipeline resets
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ir;
      logic [1:0] wbr;
      logic v, sq, wbw;
      if (i % 50 == 49) do_reset();
      ir  = 8'($urandom);
      v   = ($urandom % 4) != 0;
      sq  = ($urandom % 8) == 0;
      wbr = 2'($urandom % 4);
      wbw = (mcnt[wbr] != 0) ? 1'($urandom % 2) : (($urandom % 25) == 0);
      step("rnd", ir, v, sq, wbw, wbr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
